perfect_range_scanner: RTL and testbench
========================================

// Module: perfect_range_scanner
// PURPOSE
//  Sequencer that sits directly upstream of the perfect-number checker. Walks N over the
//  inclusive range [lo,hi]: drives n_out, pulses chk_go, waits for the checker's busy/over
//  handshake, then samples chk_isper. Perfect hits go into a small result FIFO.
//  A hit counter and sticky error flags are kept for the host/switch interface.
// PARAMETERS
//  W          16    operand width (n_out, lo, hi, FIFO data)
//  FIFO_DEPTH 4     result FIFO entries (power of 2, >=2)
//  TIMEOUT    1023  max cycles waited in each handshake phase before abandoning N
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle request to begin scan; sampled only in IDLE
//  lo         in   W   first N (captured on accepted start)
//  hi         in   W   last N, inclusive (captured on accepted start)
//  n_out      out  W   operand to checker; stable from ISSUE until RECORD
//  chk_go     out  1   1-cycle pulse to checker in ISSUE
//  chk_over   in   1   checker idle/done (1 = idle or result valid, 0 = computing)
//  chk_isper  in   1   checker verdict; valid while chk_over=1 after completion
//  busy       out  1   1 from accepted start until DONE
//  done       out  1   1-cycle pulse when scan finishes
//  hit_count  out  W   number of perfect N found in current/last scan
//  rd_en      in   1   pop FIFO head (ignored when empty)
//  rd_data    out  W   FIFO head (valid when !fifo_empty)
//  fifo_empty out  1   FIFO empty
//  overflow   out  1   sticky: hit found while FIFO full (hit dropped, still counted)
//  timeout_err out 1   sticky: some N abandoned on handshake timeout
// BEHAVIOUR
//  Reset: state=IDLE, n_out=0, chk_go=0, busy=0, done=0, hit_count=0, FIFO flushed
//   (fifo_empty=1, rd_data=0), overflow=0, timeout_err=0. Reset mid-scan aborts at once.
//  FSM: IDLE -start-> LOAD (cur=lo, end=hi, hit_count/flags cleared; FIFO NOT cleared)
//   LOAD: lo>hi -> DONE (zero N examined); else ISSUE.
//   ISSUE: n_out=cur, chk_go=1 for exactly 1 cycle, wdog=0 -> WAIT_ACK.
//   WAIT_ACK: chk_over==0 -> WAIT_DONE (wdog=0); wdog==TIMEOUT -> timeout_err=1, NEXT.
//   WAIT_DONE: chk_over==1 -> RECORD; wdog==TIMEOUT -> timeout_err=1, NEXT.
//   RECORD: if chk_isper: hit_count++, push cur if not full else overflow=1 -> NEXT.
//   NEXT: cur==end -> DONE; else cur=cur+1 -> ISSUE.
//   DONE: done=1 one cycle, busy=0 -> IDLE.
//  Per-N cost: 1 ISSUE + ack + compute + 1 RECORD + 1 NEXT cycles.
//  Wrap: hi=2^W-1 terminates on cur==end compare; cur never wraps to 0.
//  start while busy: ignored. start in same cycle as DONE: ignored (accepted next IDLE).
//  hit_count saturates at 2^W-1. wdog is W-bit wide enough for TIMEOUT; no wrap.
//  FIFO: push and pop in same cycle when full -> both occur, no overflow; when empty
//   -> pop ignored, push lands. rd_data is registered head, updates cycle after pop.
//  FIFO readable while busy and after DONE; contents persist across scans.
// STRUCTURE
//  Shared include (perfect_defs.vh): state encodings (3-bit), W default, handshake
//   polarity constants, shared with checker and top-level.
//  One sub-module: hit_fifo (sync FIFO, DEPTH/W params, push/pop/full/empty, sync rst).
//  FSM + cur/end/wdog/hit_count regs live in this module.
// TESTING (bench uses behavioural checker model with programmable latency)
//  lo=1,hi=30, real divisor model -> hit_count=2, FIFO pops 6 then 28, done once, no errs.
//  lo=500,hi=500 -> exactly one chk_go with n_out=500, hit_count=0, done pulse.
//  lo=10,hi=5 -> zero chk_go pulses, done within 3 cycles of start, hit_count=0.
//  Model flags all even N, lo=1,hi=20, no reads -> hit_count=10, FIFO holds 2,4,6,8,
//   overflow=1; then pop 4x -> fifo_empty=1.
//  Model never drops chk_over for N=7, lo=6,hi=8, TIMEOUT=15 -> timeout_err=1, scan
//   continues to 8, done pulses; then lo=65534,hi=65535 -> terminates, no wrap to 0.
//  rst asserted in WAIT_DONE -> next cycle all outputs at reset values, later start works.

Source files
------------

// File: rtl/perfect_range_scanner_pkg.sv
// Shared definitions for the perfect-number range scanner: default sizing,
// checker handshake polarity and the 3-bit sequencer state encoding.
package perfect_range_scanner_pkg;

  localparam int unsigned W_DEF          = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 1023;

  // chk_over polarity: high when the checker is idle or holds a valid verdict
  localparam logic CHK_OVER_IDLE = 1'b1;
  localparam logic CHK_OVER_BUSY = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RECORD    = 3'd5,
    ST_NEXT      = 3'd6,
    ST_DONE      = 3'd7
  } scan_state_t;

endpackage

// File: rtl/perfect_range_scanner_hit_fifo.sv
// Synchronous FIFO holding perfect-number hits.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes contents)
//   push, push_data write request; lands when not full, or when full with a pop
//   pop             read request; ignored when empty
//   rd_data         registered head value (0 when empty), updates after a pop
//   full, empty     registered occupancy flags
module perfect_range_scanner_hit_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;
  logic [W-1:0]  head_nxt;

  // Accepted operations, next occupancy and next head value
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
    // The new head may be the entry being written this cycle (FIFO had 0 or 1 left)
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = push_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage array, no reset needed: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and registered head/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      rd_data <= head_nxt;
      full    <= (count_nxt == CW'(DEPTH));
      empty   <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/perfect_range_scanner.sv
// Sequencer feeding the perfect-number checker: walks N over [lo,hi], pulses
// chk_go per N, waits for the busy/over handshake, records hits into a FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, lo, hi            scan request and inclusive range (sampled in IDLE)
//   n_out, chk_go            operand and 1-cycle start pulse to the checker
//   chk_over, chk_isper      checker idle/done flag and verdict
//   busy, done               scan in progress / 1-cycle completion pulse
//   hit_count                perfect N found in current/last scan (saturating)
//   rd_en, rd_data, fifo_empty  result FIFO read side
//   overflow, timeout_err    sticky error flags, cleared on accepted start
module perfect_range_scanner
  import perfect_range_scanner_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] n_out,
  output logic         chk_go,
  input  logic         chk_over,
  input  logic         chk_isper,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hit_count,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         fifo_empty,
  output logic         overflow,
  output logic         timeout_err
);

  scan_state_t  state;
  logic [W-1:0] cur;
  logic [W-1:0] last_n;
  logic [W-1:0] wdog;
  logic         fifo_full;
  logic         push_c;

  // Hit offered to the FIFO; it lands when there is room or a pop frees a slot
  assign push_c = (state == ST_RECORD) && chk_isper;

  perfect_range_scanner_hit_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (cur),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scan sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur         <= '0;
      last_n      <= '0;
      wdog        <= '0;
      n_out       <= '0;
      chk_go      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit_count   <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      chk_go <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur         <= lo;
            last_n      <= hi;
            hit_count   <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cur > last_n) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            n_out  <= cur;
            chk_go <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog  <= '0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (chk_over == CHK_OVER_BUSY) begin
            wdog  <= '0;
            state <= ST_WAIT_DONE;
          end else if (wdog == W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= ST_NEXT;
          end else begin
            wdog <= wdog + W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (chk_over == CHK_OVER_IDLE) begin
            state <= ST_RECORD;
          end else if (wdog == W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= ST_NEXT;
          end else begin
            wdog <= wdog + W'(1);
          end
        end
        ST_RECORD: begin
          if (chk_isper) begin
            if (hit_count != {W{1'b1}}) begin
              hit_count <= hit_count + W'(1);
            end
            // A simultaneous pop makes room, so only a full FIFO without a read drops the hit
            if (fifo_full && !rd_en) begin
              overflow <= 1'b1;
            end
          end
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          // Compare before increment so hi = all-ones ends without wrapping cur
          if (cur == last_n) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            cur    <= cur + W'(1);
            n_out  <= cur + W'(1);
            chk_go <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perfect_range_scanner.sv
// Directed bench for perfect_range_scanner with a behavioural checker model
// (programmable latency, real-divisor or even-number verdicts, stuck operand).
module tb_perfect_range_scanner;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] n_out;
  logic         chk_go;
  logic         chk_over;
  logic         chk_isper;
  logic         busy;
  logic         done;
  logic [W-1:0] hit_count;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         fifo_empty;
  logic         overflow;
  logic         timeout_err;

  int tests = 0;
  int fails = 0;

  // Checker model configuration
  int           lat;
  int           mode;      // 0: true perfect numbers, 1: every even N
  logic         stuck_en;
  logic [W-1:0] stuck_n;

  logic         m_over;
  logic         m_isper;
  int           m_cnt;
  logic [W-1:0] m_n;

  int           go_cnt = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_go_n = '0;

  perfect_range_scanner #(
    .W          (16),
    .FIFO_DEPTH (4),
    .TIMEOUT    (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .lo          (lo),
    .hi          (hi),
    .n_out       (n_out),
    .chk_go      (chk_go),
    .chk_over    (chk_over),
    .chk_isper   (chk_isper),
    .busy        (busy),
    .done        (done),
    .hit_count   (hit_count),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_perfect(input int n);
    int sum;
    if (n < 2) return 1'b0;
    sum = 1;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) begin
        sum += d;
        if (d != n / d) sum += n / d;
      end
    end
    return (sum == n);
  endfunction

  // Behavioural checker: drops over after chk_go, raises it with a verdict after lat cycles
  always @(posedge clk) begin
    if (rst) begin
      m_over  <= 1'b1;
      m_isper <= 1'b0;
      m_cnt   <= 0;
      m_n     <= '0;
    end else if (chk_go && !(stuck_en && n_out == stuck_n)) begin
      m_over  <= 1'b0;
      m_isper <= 1'b0;
      m_cnt   <= lat;
      m_n     <= n_out;
    end else if (!m_over) begin
      if (m_cnt <= 1) begin
        m_over  <= 1'b1;
        m_isper <= (mode == 1) ? !m_n[0] : is_perfect(int'(m_n));
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign chk_over  = m_over;
  assign chk_isper = m_isper;

  // Pulse monitors
  always @(posedge clk) begin
    if (chk_go) begin
      go_cnt    <= go_cnt + 1;
      last_go_n <= n_out;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [W-1:0] l, input logic [W-1:0] h);
    lo    = l;
    hi    = h;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int base_go;
    int base_done;
    int cyc;
    int k;

    rst = 1'b1; start = 1'b0; lo = '0; hi = '0; rd_en = 1'b0;
    lat = 2; mode = 0; stuck_en = 1'b0; stuck_n = '0;
    tick(); tick();

    // Reset state
    check("rst_n_out", 32'(n_out), 32'd0);
    check("rst_ctrl", {28'd0, chk_go, busy, done, fifo_empty}, 32'd1);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_flags", {30'd0, overflow, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();

    // 1..30 with real divisor model; a start mid-scan must be ignored
    base_go = go_cnt; base_done = done_cnt;
    pulse_start(16'd1, 16'd30);
    check("t1_busy", 32'(busy), 32'd1);
    repeat (20) tick();
    pulse_start(16'd0, 16'd0);
    wait_done("t1", 2000, cyc);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_hit_count", 32'(hit_count), 32'd2);
    tick();
    check("t1_done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("t1_done_low", 32'(done), 32'd0);
    check("t1_go_pulses", 32'(go_cnt - base_go), 32'd30);
    check("t1_flags", {30'd0, overflow, timeout_err}, 32'd0);
    check("t1_fifo_empty", 32'(fifo_empty), 32'd0);
    check("t1_pop0", 32'(rd_data), 32'd6);
    pop_one();
    check("t1_pop1", 32'(rd_data), 32'd28);
    pop_one();
    check("t1_empty_after", 32'(fifo_empty), 32'd1);

    // Single-element range
    base_go = go_cnt; base_done = done_cnt;
    pulse_start(16'd500, 16'd500);
    wait_done("t2", 200, cyc);
    check("t2_hit_count", 32'(hit_count), 32'd0);
    tick();
    check("t2_go_pulses", 32'(go_cnt - base_go), 32'd1);
    check("t2_go_n", 32'(last_go_n), 32'd500);
    check("t2_done_pulses", 32'(done_cnt - base_done), 32'd1);

    // Empty range lo > hi
    base_go = go_cnt;
    pulse_start(16'd10, 16'd5);
    wait_done("t3", 3, cyc);
    check("t3_latency_ok", 32'(cyc <= 2), 32'd1);
    check("t3_hit_count", 32'(hit_count), 32'd0);
    tick();
    check("t3_go_pulses", 32'(go_cnt - base_go), 32'd0);

    // All even N flagged, FIFO overflows with no reads
    mode = 1;
    pulse_start(16'd1, 16'd20);
    wait_done("t4", 2000, cyc);
    check("t4_hit_count", 32'(hit_count), 32'd10);
    check("t4_overflow", 32'(overflow), 32'd1);
    tick();
    check("t4_head0", 32'(rd_data), 32'd2);
    pop_one();
    check("t4_head1", 32'(rd_data), 32'd4);
    pop_one();
    check("t4_head2", 32'(rd_data), 32'd6);
    pop_one();
    check("t4_head3", 32'(rd_data), 32'd8);
    pop_one();
    check("t4_empty", 32'(fifo_empty), 32'd1);
    check("t4_rd_data_empty", 32'(rd_data), 32'd0);

    // Checker never acknowledges N=7: timeout, scan continues to 8
    mode = 0; stuck_en = 1'b1; stuck_n = 16'd7;
    base_go = go_cnt;
    pulse_start(16'd6, 16'd8);
    wait_done("t5", 500, cyc);
    check("t5_timeout_err", 32'(timeout_err), 32'd1);
    check("t5_hit_count", 32'(hit_count), 32'd1);
    tick();
    check("t5_go_pulses", 32'(go_cnt - base_go), 32'd3);
    check("t5_last_n", 32'(last_go_n), 32'd8);
    check("t5_fifo_head", 32'(rd_data), 32'd6);

    // Top of range: must stop at 65535 without wrapping
    stuck_en = 1'b0;
    base_go = go_cnt;
    pulse_start(16'd65534, 16'd65535);
    wait_done("t6", 500, cyc);
    check("t6_flags_cleared", {30'd0, overflow, timeout_err}, 32'd0);
    check("t6_hit_count", 32'(hit_count), 32'd0);
    repeat (10) tick();
    check("t6_go_pulses", 32'(go_cnt - base_go), 32'd2);
    check("t6_last_n", 32'(last_go_n), 32'd65535);
    check("t6_idle", 32'(busy), 32'd0);

    // Reset while waiting for the checker to finish
    lat = 20;
    pulse_start(16'd100, 16'd100);
    k = 0;
    while (chk_go !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("t7_go_seen", 32'(chk_go), 32'd1);
    tick(); tick();
    check("t7_pre_busy", 32'(busy), 32'd1);
    check("t7_pre_fifo", 32'(fifo_empty), 32'd0);
    rst = 1'b1;
    tick();
    check("t7_rst_ctrl", {28'd0, chk_go, busy, done, fifo_empty}, 32'd1);
    check("t7_rst_n_out", 32'(n_out), 32'd0);
    check("t7_rst_rd_data", 32'(rd_data), 32'd0);
    check("t7_rst_hits_flags", {14'd0, hit_count, overflow, timeout_err}, 32'd0);
    rst = 1'b0;
    lat = 2;
    tick();
    pulse_start(16'd28, 16'd28);
    wait_done("t7_after", 200, cyc);
    check("t7_hit_count", 32'(hit_count), 32'd1);
    check("t7_fifo_head", 32'(rd_data), 32'd28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
